// File: rtl/mmio_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmio_initiator                                                |
// | Purpose  : Host-side MMIO request initiator. Turns single-beat commands  |
// |            into one-cycle MMIO write/read request pulses toward an AFU,  |
// |            waits for the read response carrying the matching TID and     |
// |            returns its data, or reports a timeout error.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n                   clock / asynchronous active-low reset     |
// |   cmd_valid_i / cmd_ready_o    command handshake (ready only when idle)  |
// |   cmd_wr_i, cmd_addr_i,        command: 1=write, address, write data     |
// |   cmd_wdata_i                                                            |
// |   mmio_wr_valid_o              one-cycle write request pulse             |
// |   mmio_rd_valid_o              one-cycle read request pulse              |
// |   mmio_addr_o, mmio_tid_o,     request fields, held between requests     |
// |   mmio_wdata_o                                                           |
// |   rsp_valid_i, rsp_tid_i,      read response from the responder          |
// |   rsp_data_i                                                             |
// |   res_valid_o                  one-cycle read result pulse               |
// |   res_data_o, res_err_o        result data (0 on timeout), timeout flag  |
// |   busy_o                       FSM is not idle                           |
// +--------------------------------------------------------------------------+
module mmio_initiator #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int TID_W   = 9,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              mmio_wr_valid_o,
  output logic              mmio_rd_valid_o,
  output logic [ADDR_W-1:0] mmio_addr_o,
  output logic [TID_W-1:0]  mmio_tid_o,
  output logic [DATA_W-1:0] mmio_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [TID_W-1:0]  rsp_tid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e              state_q;
  logic [TID_W-1:0]    tid_q;        // TID for the next read
  logic [CNT_W-1:0]    cnt_q;        // cycles spent in WAIT
  logic                wr_valid_q;
  logic                rd_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [TID_W-1:0]    req_tid_q;    // TID of the request on the bus
  logic [DATA_W-1:0]   wdata_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic                res_err_q;

  logic                rsp_match;

  // Responses are only compared against the TID of the outstanding read.
  assign rsp_match = rsp_valid_i && (rsp_tid_i == req_tid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tid_q       <= '0;
      cnt_q       <= '0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      addr_q      <= '0;
      req_tid_q   <= '0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            addr_q    <= cmd_addr_i;
            wdata_q   <= cmd_wdata_i;
            req_tid_q <= tid_q;
            if (cmd_wr_i) begin
              state_q    <= ST_WR;
              wr_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_RD;
              rd_valid_q <= 1'b1;
            end
          end
        end
        // Writes are posted: no result and the TID is not consumed.
        ST_WR: state_q <= ST_IDLE;
        ST_RD: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          // A match on the final counted cycle still beats the timeout.
          if (rsp_match) begin
            res_valid_q <= 1'b1;
            res_data_q  <= rsp_data_i;
            res_err_q   <= 1'b0;
            tid_q       <= tid_q + 1'b1;
            state_q     <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            res_valid_q <= 1'b1;
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            tid_q       <= tid_q + 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o     = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign mmio_wr_valid_o = wr_valid_q;
  assign mmio_rd_valid_o = rd_valid_q;
  assign mmio_addr_o     = addr_q;
  assign mmio_tid_o      = req_tid_q;
  assign mmio_wdata_o    = wdata_q;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_err_o       = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mmio_initiator                                             |
// | Purpose  : Directed self-checking bench for mmio_initiator. dut_a uses   |
// |            TID_W=9, dut_b uses TID_W=2 for the TID wrap scenario; both   |
// |            use TIMEOUT=16 and share the command/response stimulus.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid = 1'b0;
  logic [8:0]  rsp_tid = '0;
  logic [63:0] rsp_data = '0;

  logic        a_cmd_ready, a_wr_valid, a_rd_valid, a_res_valid, a_res_err, a_busy;
  logic [15:0] a_addr;
  logic [8:0]  a_tid;
  logic [63:0] a_wdata, a_res_data;

  logic        b_cmd_ready, b_wr_valid, b_rd_valid, b_res_valid, b_res_err, b_busy;
  logic [15:0] b_addr;
  logic [1:0]  b_tid;
  logic [63:0] b_wdata, b_res_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_initiator #(.ADDR_W(16), .DATA_W(64), .TID_W(9), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(a_cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .mmio_wr_valid_o(a_wr_valid), .mmio_rd_valid_o(a_rd_valid),
    .mmio_addr_o(a_addr), .mmio_tid_o(a_tid), .mmio_wdata_o(a_wdata),
    .rsp_valid_i(rsp_valid), .rsp_tid_i(rsp_tid), .rsp_data_i(rsp_data),
    .res_valid_o(a_res_valid), .res_data_o(a_res_data), .res_err_o(a_res_err),
    .busy_o(a_busy)
  );

  mmio_initiator #(.ADDR_W(16), .DATA_W(64), .TID_W(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .mmio_wr_valid_o(b_wr_valid), .mmio_rd_valid_o(b_rd_valid),
    .mmio_addr_o(b_addr), .mmio_tid_o(b_tid), .mmio_wdata_o(b_wdata),
    .rsp_valid_i(rsp_valid), .rsp_tid_i(rsp_tid[1:0]), .rsp_data_i(rsp_data),
    .res_valid_o(b_res_valid), .res_data_o(b_res_data), .res_err_o(b_res_err),
    .busy_o(b_busy)
  );

  // Request pulses on dut_a: never both at once, never two cycles in a row.
  logic a_prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ((a_rd_valid && a_wr_valid) || (a_prev_pulse && (a_rd_valid || a_wr_valid))) begin
        n_bad++;
        $display("FAIL pulse_rule: rd=%0b wr=%0b prev=%0b, required no overlap and no back-to-back",
                 a_rd_valid, a_wr_valid, a_prev_pulse);
      end
      a_prev_pulse = a_rd_valid || a_wr_valid;
    end else begin
      a_prev_pulse = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Offer one command; returns in cycle E+1 (just after the accepting edge).
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [63:0] data);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({a_wr_valid, a_rd_valid, a_res_valid, a_res_err, a_busy, a_cmd_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_ctrl: got wr,rd,res,err,busy,ready=%b required 000001",
               {a_wr_valid, a_rd_valid, a_res_valid, a_res_err, a_busy, a_cmd_ready});
    end
    n_cmp++;
    if ({a_addr, a_tid, a_wdata, a_res_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%0h tid=%0h wdata=%0h res_data=%0h required all 0",
               a_addr, a_tid, a_wdata, a_res_data);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write;
    issue(1'b1, 16'h0020, 64'hDEADBEEF_CAFEF00D);
    n_cmp++;
    if ({a_wr_valid, a_rd_valid, a_cmd_ready, a_busy, a_res_valid} !== 5'b10010) begin
      n_bad++;
      $display("FAIL wr_pulse: got wr,rd,ready,busy,res=%b required 10010",
               {a_wr_valid, a_rd_valid, a_cmd_ready, a_busy, a_res_valid});
    end
    n_cmp++;
    if (a_addr !== 16'h0020 || a_wdata !== 64'hDEADBEEF_CAFEF00D || a_tid !== 9'd0) begin
      n_bad++;
      $display("FAIL wr_fields: got addr=%0h wdata=%0h tid=%0h required 20 deadbeefcafef00d 0",
               a_addr, a_wdata, a_tid);
    end
    tick;
    n_cmp++;
    if ({a_wr_valid, a_cmd_ready, a_busy, a_res_valid} !== 4'b0100) begin
      n_bad++;
      $display("FAIL wr_done: got wr,ready,busy,res=%b required 0100",
               {a_wr_valid, a_cmd_ready, a_busy, a_res_valid});
    end
  endtask

  task automatic test_read;
    issue(1'b0, 16'h0020, 64'h0);
    n_cmp++;
    if (a_rd_valid !== 1'b1 || a_wr_valid !== 1'b0 || a_tid !== 9'd0 || a_addr !== 16'h0020) begin
      n_bad++;
      $display("FAIL rd_req: got rd=%0b wr=%0b tid=%0h addr=%0h required 1 0 0 20",
               a_rd_valid, a_wr_valid, a_tid, a_addr);
    end
    tick;  // E+2: responder answers
    n_cmp++;
    if (a_rd_valid !== 1'b0 || a_cmd_ready !== 1'b0 || a_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_wait: got rd=%0b ready=%0b res=%0b required 0 0 0",
               a_rd_valid, a_cmd_ready, a_res_valid);
    end
    rsp_valid = 1'b1; rsp_tid = 9'd0; rsp_data = 64'h1234;
    tick;  // E+3
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_err !== 1'b0 || a_res_data !== 64'h1234 || a_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_result: got valid=%0b err=%0b data=%0h ready=%0b required 1 0 1234 1",
               a_res_valid, a_res_err, a_res_data, a_cmd_ready);
    end
    tick;
    n_cmp++;
    if (a_res_valid !== 1'b0 || a_res_data !== 64'h1234) begin
      n_bad++;
      $display("FAIL rd_hold: got valid=%0b data=%0h required 0 1234", a_res_valid, a_res_data);
    end
    issue(1'b0, 16'h0024, 64'h0);
    n_cmp++;
    if (a_tid !== 9'd1 || a_rd_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rd2_tid: got tid=%0h rd=%0b required 1 1", a_tid, a_rd_valid);
    end
    tick;
    rsp_valid = 1'b1; rsp_tid = 9'd1; rsp_data = 64'h5678;
    tick;
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_data !== 64'h5678) begin
      n_bad++;
      $display("FAIL rd2_result: got valid=%0b data=%0h required 1 5678", a_res_valid, a_res_data);
    end
    tick;
  endtask

  task automatic test_mismatch;
    do_reset;
    issue(1'b0, 16'h0002, 64'h0);
    tick;  // E+2
    rsp_valid = 1'b1; rsp_tid = 9'd5; rsp_data = 64'hBAD;
    tick;  // E+3
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b0 || a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mis_ignored: got res=%0b busy=%0b required 0 1", a_res_valid, a_busy);
    end
    tick;  // E+4
    n_cmp++;
    if (a_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_quiet: got res=%0b required 0", a_res_valid);
    end
    rsp_valid = 1'b1; rsp_tid = 9'd0; rsp_data = 64'h600D;
    tick;  // E+5
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_err !== 1'b0 || a_res_data !== 64'h600D) begin
      n_bad++;
      $display("FAIL mis_result: got valid=%0b err=%0b data=%0h required 1 0 600d",
               a_res_valid, a_res_err, a_res_data);
    end
    tick;
    n_cmp++;
    if (a_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_single: got res=%0b required 0", a_res_valid);
    end
  endtask

  // Current TID is 1 here (one read completed since the last reset).
  task automatic test_timeout;
    issue(1'b0, 16'h0040, 64'h0);
    n_cmp++;
    if (a_tid !== 9'd1) begin
      n_bad++;
      $display("FAIL to_tid: got %0h required 1", a_tid);
    end
    tick;  // E+2, WAIT entry
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (a_res_valid !== 1'b0 || a_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL to_early: wait cycle %0d got res=%0b busy=%0b required 0 1", k, a_res_valid, a_busy);
      end
      tick;
    end
    // Now in cycle E+18 = WAIT entry + 16
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_err !== 1'b1 || a_res_data !== 64'h0 || a_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL to_result: got valid=%0b err=%0b data=%0h ready=%0b required 1 1 0 1",
               a_res_valid, a_res_err, a_res_data, a_cmd_ready);
    end
    rsp_valid = 1'b1; rsp_tid = 9'd1; rsp_data = 64'h77;  // late response
    tick;
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL to_late: got res=%0b required 0", a_res_valid);
    end
    tick;
    n_cmp++;
    if (a_res_valid !== 1'b0 || a_res_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_hold: got res=%0b err=%0b required 0 1", a_res_valid, a_res_err);
    end
    issue(1'b0, 16'h0044, 64'h0);
    n_cmp++;
    if (a_tid !== 9'd2) begin
      n_bad++;
      $display("FAIL to_next_tid: got %0h required 2", a_tid);
    end
    tick;
    rsp_valid = 1'b1; rsp_tid = 9'd2; rsp_data = 64'hABC;
    tick;
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_err !== 1'b0 || a_res_data !== 64'hABC) begin
      n_bad++;
      $display("FAIL to_next_result: got valid=%0b err=%0b data=%0h required 1 0 abc",
               a_res_valid, a_res_err, a_res_data);
    end
    tick;
  endtask

  // Response on the last counted WAIT cycle (counter 15) must still win.
  task automatic test_last_cycle_match;
    issue(1'b0, 16'h0048, 64'h0);
    tick;  // E+2
    for (int k = 0; k < 15; k++) tick;
    rsp_valid = 1'b1; rsp_tid = 9'd3; rsp_data = 64'hF1;
    tick;
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_err !== 1'b0 || a_res_data !== 64'hF1) begin
      n_bad++;
      $display("FAIL last_match: got valid=%0b err=%0b data=%0h required 1 0 f1",
               a_res_valid, a_res_err, a_res_data);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 16'h0050, 64'h0);
    tick;  // in WAIT
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_wr_valid, a_rd_valid, a_res_valid, a_res_err, a_busy, a_cmd_ready} !== 6'b000001 ||
        a_tid !== 9'd0 || a_addr !== 16'h0 || a_res_data !== 64'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got ctrl=%b tid=%0h addr=%0h data=%0h required 000001 0 0 0",
               {a_wr_valid, a_rd_valid, a_res_valid, a_res_err, a_busy, a_cmd_ready},
               a_tid, a_addr, a_res_data);
    end
    rst_n = 1'b1;
    tick;
    rsp_valid = 1'b1; rsp_tid = 9'd4; rsp_data = 64'h99;
    tick;
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b0 || a_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_late: got res=%0b ready=%0b required 0 1", a_res_valid, a_cmd_ready);
    end
    issue(1'b0, 16'h0054, 64'h0);
    n_cmp++;
    if (a_tid !== 9'd0) begin
      n_bad++;
      $display("FAIL mid_next_tid: got %0h required 0", a_tid);
    end
    tick;
    rsp_valid = 1'b1; rsp_tid = 9'd0; rsp_data = 64'h42;
    tick;
    rsp_valid = 1'b0;
    n_cmp++;
    if (a_res_valid !== 1'b1 || a_res_data !== 64'h42) begin
      n_bad++;
      $display("FAIL mid_next_result: got valid=%0b data=%0h required 1 42", a_res_valid, a_res_data);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_tid [5];
    exp_tid[0] = 2'd0; exp_tid[1] = 2'd1; exp_tid[2] = 2'd2; exp_tid[3] = 2'd3; exp_tid[4] = 2'd0;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (b_cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready: read %0d got %0b required 1", i, b_cmd_ready);
      end
      issue(1'b0, 16'h0100 + 16'(i), 64'h0);
      n_cmp++;
      if (b_tid !== exp_tid[i] || b_rd_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_tid: read %0d got tid=%0d rd=%0b required %0d 1", i, b_tid, b_rd_valid, exp_tid[i]);
      end
      tick;
      rsp_valid = 1'b1; rsp_tid = {7'd0, exp_tid[i]}; rsp_data = 64'h1000 + 64'(i);
      tick;
      rsp_valid = 1'b0;
      n_cmp++;
      if (b_res_valid !== 1'b1 || b_res_err !== 1'b0 || b_res_data !== 64'h1000 + 64'(i)) begin
        n_bad++;
        $display("FAIL b2b_result: read %0d got valid=%0b err=%0b data=%0h required 1 0 %0h",
                 i, b_res_valid, b_res_err, b_res_data, 64'h1000 + 64'(i));
      end
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_timeout;
    test_last_cycle_match;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
